// File: rtl/spi_reg_pkg.sv
// Shared frame layout, register map and FSM encoding for the SPI register block.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_MAX    = FRAME_BITS + 1;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, plus a history flop that
// turns level changes into single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 target: deserializes 16-bit frames and commits valid
// writes into the five PWM control registers.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic sclk_rise, unused_sclk_level, unused_sclk_fall;
  logic copi_s, unused_copi_rise, unused_copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(unused_sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi),
    .level(copi_s), .rise(unused_copi_rise), .fall(unused_copi_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  // The synchronizer resets to ncs=1, so a pin already low at reset release
  // would look like a fresh falling edge. Frames are only accepted once the
  // pipeline has flushed and ncs has genuinely been seen high.
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   armed_q;
  logic                   frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_q  <= armed_q | (settle_q[SYNC_STAGES-1] & ncs_level);
    end
  end

  assign frame_start = ncs_fall & armed_q;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] shreg_q;
  logic [6:0]  frame_addr;
  logic        frame_ok;

  assign frame_addr = shreg_q[14:8];
  assign frame_ok   = (cnt_q == 5'(FRAME_BITS)) && shreg_q[15] &&
                      (frame_addr <= 7'(MAX_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      shreg_q         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        // A coincident sclk edge is dropped when ncs rises.
        SHIFT: begin
          if (ncs_rise) begin
            state_q <= COMMIT;
          end else if (frame_start) begin
            cnt_q   <= '0;
            shreg_q <= '0;
          end else if (sclk_rise) begin
            shreg_q <= {shreg_q[14:0], copi_s};
            if (cnt_q != 5'(CNT_MAX)) cnt_q <= cnt_q + 5'd1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (frame_ok) begin
            case (frame_addr)
              ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg_q[7:0];
              ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg_q[7:0];
              ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg_q[7:0];
              ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg_q[7:0];
              ADDR_DUTY:      pwm_duty_cycle  <= shreg_q[7:0];
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: bit-banged SPI frames with
// hand-computed register expectations.
module tb_spi_reg_peripheral;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = SYNC_STAGES + 4;
  localparam int LATENCY     = SYNC_STAGES + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       copi  = 1'b0;
  logic       ncs   = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_reg_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, actual, expected);
    end
  endtask

  task automatic checkAllRegs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    checkOutput({tag, "/reg0"}, en_reg_out_7_0, e0);
    checkOutput({tag, "/reg1"}, en_reg_out_15_8, e1);
    checkOutput({tag, "/reg2"}, en_reg_pwm_7_0, e2);
    checkOutput({tag, "/reg3"}, en_reg_pwm_15_8, e3);
    checkOutput({tag, "/reg4"}, pwm_duty_cycle, e4);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beginFrame();
    @(negedge clk);
    ncs = 1'b0;
    waitCycles(HALF);
  endtask

  // Mode 0: data is set while sclk is low and sampled on the rising edge.
  task automatic shiftBit(input logic b, input bit raise_ncs);
    copi = b;
    waitCycles(HALF);
    sclk = 1'b1;
    if (raise_ncs) ncs = 1'b1;
    waitCycles(HALF);
    sclk = 1'b0;
  endtask

  task automatic endFrame();
    waitCycles(HALF);
    ncs = 1'b1;
  endtask

  // Sends the low nbits of word MSB first; simul raises ncs with the last sclk edge.
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input bit simul);
    beginFrame();
    for (int i = 0; i < nbits; i++) begin
      shiftBit(word[nbits-1-i], simul && (i == nbits - 1));
    end
    if (!simul) endFrame();
  endtask

  initial begin
    logic [15:0] partial;

    rst_n = 1'b0;
    ncs   = 1'b1;
    waitCycles(3);
    checkAllRegs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    waitCycles(20);
    checkAllRegs("idle_after_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    applyStimulus(32'h80F0, 16, 1'b0);
    waitCycles(LATENCY - 1);
    checkOutput("latency_before", en_reg_out_7_0, 8'h00);
    waitCycles(1);
    checkOutput("latency_after", en_reg_out_7_0, 8'hF0);
    waitCycles(4);
    checkAllRegs("write_reg0", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

    applyStimulus(32'h8480, 16, 1'b0);
    waitCycles(8);
    checkAllRegs("write_duty", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);

    applyStimulus(32'h0055, 16, 1'b0);
    waitCycles(8);
    checkAllRegs("drop_read", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    applyStimulus(32'h8A55, 16, 1'b0);
    waitCycles(8);
    checkAllRegs("drop_addr", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    applyStimulus(32'h4011, 15, 1'b0);
    waitCycles(8);
    checkAllRegs("drop_short", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    applyStimulus(32'h1_8033, 17, 1'b0);
    waitCycles(8);
    checkAllRegs("drop_long", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);

    applyStimulus(32'h8101, 16, 1'b0);
    waitCycles(LATENCY - 1);
    applyStimulus(32'h8202, 16, 1'b0);
    waitCycles(8);
    checkAllRegs("back_to_back", 8'hF0, 8'h01, 8'h02, 8'h00, 8'h80);

    partial = 16'h83AA;
    beginFrame();
    for (int i = 0; i < 8; i++) shiftBit(partial[15-i], 1'b0);
    rst_n = 1'b0;
    waitCycles(2);
    checkAllRegs("midframe_in_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    waitCycles(3);
    for (int i = 8; i < 16; i++) shiftBit(partial[15-i], 1'b0);
    endFrame();
    waitCycles(8);
    checkAllRegs("midframe_dropped", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(32'h83AA, 16, 1'b0);
    waitCycles(8);
    checkAllRegs("after_midframe", 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00);

    applyStimulus(32'h8477, 16, 1'b1);
    waitCycles(8);
    checkAllRegs("simultaneous_edges", 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00);
    applyStimulus(32'h8455, 16, 1'b0);
    waitCycles(8);
    checkAllRegs("write_after_simul", 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
